input_conditioner: RTL and testbench

//  Front end of the game controller. Turns raw active-low push-buttons into clean,

---
 rtl/input_conditioner.sv | 256 +++++++++++++++++++++++++
 tb/tb_input_conditioner.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: debounces three active-low push-buttons into one-cycle
// move/rotate pulses and generates the periodic gravity tick strobe.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   reset         in   synchronous, active-high
//   key_left_n    in   raw button, asynchronous, 0 = pressed
//   key_right_n   in   raw button, asynchronous, 0 = pressed
//   key_rot_n     in   raw button, asynchronous, 0 = pressed
//   grav_enable   in   1 = gravity counter runs, 0 = held at 0
//   soft_drop     in   1 = fast gravity period
//   left_final    out  one-cycle move-left request
//   right_final   out  one-cycle move-right request
//   rot_final     out  one-cycle rotate request
//   tick_gravity  out  one-cycle gravity strobe
//
// Optional feature: define INPUT_COND_AUTO_REPEAT_EN to auto-repeat
// held left/right keys (first repeat after REPEAT_DELAY cycles, then
// every REPEAT_RATE cycles). Rotate never repeats.

module input_conditioner #(
  parameter int DB_CYCLES    = 1_000_000,
  parameter int GRAV_CYCLES  = 25_000_000,
  parameter int FAST_CYCLES  = 2_500_000,
  parameter int REPEAT_DELAY = 15_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_rot_n,
  input  logic grav_enable,
  input  logic soft_drop,
  output logic left_final,
  output logic right_final,
  output logic rot_final,
  output logic tick_gravity
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int GW  = $clog2(GRAV_CYCLES);

  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DB_CYCLES - 1);
  localparam logic [GW-1:0] GRAV_LAST =
    GW'(GRAV_CYCLES - 1);
  localparam logic [GW-1:0] FAST_LAST =
    GW'(FAST_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DB_CYCLES < 1) begin : g_chk_db
    $error("DB_CYCLES must be >= 1");
  end
  if (GRAV_CYCLES < 2) begin : g_chk_grav
    $error("GRAV_CYCLES must be >= 2");
  end
  if (FAST_CYCLES < 1 ||
      FAST_CYCLES >= GRAV_CYCLES) begin : g_chk_fast
    $error("FAST_CYCLES must be in [1, GRAV_CYCLES)");
  end
  if (REPEAT_DELAY < 1 ||
      REPEAT_RATE < 1) begin : g_chk_rpt
    $error("REPEAT_DELAY/REPEAT_RATE must be >= 1");
  end

  // ------------------------------------------------------------
  // Key index: 0 = left, 1 = right, 2 = rotate
  // ------------------------------------------------------------
  logic [2:0] raw_n;
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic [2:0] pressed;

  assign raw_n = {key_rot_n, key_right_n, key_left_n};

  // Synchronisers reset to the released level so a key held
  // through reset is debounced as a fresh press afterwards.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= raw_n;
      sync_q <= meta_q;
    end
  end

  assign pressed = ~sync_q;

  // ------------------------------------------------------------
  // Debounce: flip the stable level only after the synced level
  // has disagreed with it for DB_CYCLES consecutive cycles.
  // ------------------------------------------------------------
  logic [2:0]     stab_q;
  logic [2:0]     stab_d;
  logic [2:0]     stab_dly_q;
  logic [DBW-1:0] db_q [3];
  logic [DBW-1:0] db_d [3];

  always_comb begin
    stab_d = stab_q;
    for (int k = 0; k < 3; k++) begin
      db_d[k] = '0;
      if (pressed[k] != stab_q[k]) begin
        if (db_q[k] == DB_LAST) begin
          stab_d[k] = pressed[k];
        end else begin
          db_d[k] = db_q[k] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stab_q     <= '0;
      stab_dly_q <= '0;
      for (int k = 0; k < 3; k++) begin
        db_q[k] <= '0;
      end
    end else begin
      stab_q     <= stab_d;
      stab_dly_q <= stab_q;
      for (int k = 0; k < 3; k++) begin
        db_q[k] <= db_d[k];
      end
    end
  end

  // Stable 0->1 transition seen this cycle
  logic [2:0] rise;
  assign rise = stab_q & ~stab_dly_q;

  // Pulse requests before the left/right conflict filter
  logic [2:0] req;

`ifdef INPUT_COND_AUTO_REPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ?
    REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [RW-1:0] R_DELAY =
    RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE =
    RW'(REPEAT_RATE);

  // rpt_q counts cycles since the last pulse of a held key;
  // rph_q marks that the initial delay has already elapsed.
  logic [RW-1:0] rpt_q [2];
  logic [RW-1:0] rpt_d [2];
  logic [1:0]    rph_q;
  logic [1:0]    rph_d;
  logic [1:0]    rfire;

  always_comb begin
    rph_d = '0;
    rfire = '0;
    for (int k = 0; k < 2; k++) begin
      rpt_d[k] = '0;
      if (stab_q[k]) begin
        if (rpt_q[k] ==
            (rph_q[k] ? R_RATE : R_DELAY)) begin
          rfire[k] = 1'b1;
          rpt_d[k] = RW'(1);
          rph_d[k] = 1'b1;
        end else begin
          rpt_d[k] = rpt_q[k] + RW'(1);
          rph_d[k] = rph_q[k];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rph_q <= '0;
      for (int k = 0; k < 2; k++) begin
        rpt_q[k] <= '0;
      end
    end else begin
      rph_q <= rph_d;
      for (int k = 0; k < 2; k++) begin
        rpt_q[k] <= rpt_d[k];
      end
    end
  end

  assign req = {rise[2], rise[1:0] | rfire};
`else
  assign req = rise;
`endif

  // ------------------------------------------------------------
  // Output pulses: simultaneous left and right cancel each other.
  // ------------------------------------------------------------
  logic left_q;
  logic left_d;
  logic right_q;
  logic right_d;
  logic rot_q;
  logic rot_d;

  always_comb begin
    left_d  = req[0] & ~req[1];
    right_d = req[1] & ~req[0];
    rot_d   = req[2];
  end

  // ------------------------------------------------------------
  // Gravity: >= compare so a shorter limit selected mid-count
  // wraps on the next cycle instead of running past it.
  // ------------------------------------------------------------
  logic [GW-1:0] grav_q;
  logic [GW-1:0] grav_d;
  logic [GW-1:0] grav_last;
  logic          tick_q;
  logic          tick_d;

  assign grav_last = soft_drop ? FAST_LAST : GRAV_LAST;

  always_comb begin
    grav_d = '0;
    tick_d = 1'b0;
    if (grav_enable) begin
      if (grav_q >= grav_last) begin
        tick_d = 1'b1;
      end else begin
        grav_d = grav_q + GW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      rot_q   <= 1'b0;
      tick_q  <= 1'b0;
      grav_q  <= '0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      rot_q   <= rot_d;
      tick_q  <= tick_d;
      grav_q  <= grav_d;
    end
  end

  assign left_final   = left_q;
  assign right_final  = right_q;
  assign rot_final    = rot_q;
  assign tick_gravity = tick_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus for input_conditioner
// checked every cycle against a window-based behavioural model.

module tb_input_conditioner;

  localparam int DB = 4;
  localparam int GR = 10;
  localparam int FA = 3;
  localparam int RD = 8;
  localparam int RR = 3;

`ifdef INPUT_COND_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic kl    = 1'b1;
  logic kr    = 1'b1;
  logic ko    = 1'b1;
  logic ge    = 1'b0;
  logic sd    = 1'b0;
  logic lf;
  logic rf;
  logic of;
  logic tg;

  always #5 clk = ~clk;

  input_conditioner #(
    .DB_CYCLES   (DB),
    .GRAV_CYCLES (GR),
    .FAST_CYCLES (FA),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .key_left_n  (kl),
    .key_right_n (kr),
    .key_rot_n   (ko),
    .grav_enable (ge),
    .soft_drop   (sd),
    .left_final  (lf),
    .right_final (rf),
    .rot_final   (of),
    .tick_gravity(tg)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit m_s  [3];
  bit m_s1 [3];
  bit d1   [3];
  bit d2   [3];
  bit w    [3][DB];
  int wn   [3];
  int p0   [2];
  int e;
  int edge_n;
  bit xl;
  bit xr;
  bit xo;
  bit xt;

  // Observation counters for directed checks
  int ph;
  int nl;
  int nr;
  int no;
  int nt;
  int fl;
  int fo;
  int ft;
  int ll;
  int lt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, got, exp);
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    bit pr [3];
    bit f  [3];
    bit sy;
    bit all;
    int d;
    edge_n++;
    pr[0] = ~kl;
    pr[1] = ~kr;
    pr[2] = ~ko;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_s[k]  = 1'b0;
        m_s1[k] = 1'b0;
        d1[k]   = 1'b0;
        d2[k]   = 1'b0;
        wn[k]   = 0;
      end
      xl = 1'b0;
      xr = 1'b0;
      xo = 1'b0;
      xt = 1'b0;
      e  = 0;
      return;
    end
    // Pulse requests: fresh press, or held-key repeat schedule
    for (int k = 0; k < 3; k++) begin
      f[k] = m_s[k] & ~m_s1[k];
      if (k < 2) begin
        if (f[k]) begin
          p0[k] = edge_n;
        end else if (AR && m_s[k]) begin
          d = edge_n - p0[k];
          f[k] = (d >= RD) && ((d - RD) % RR == 0);
        end
      end
    end
    xl = f[0] & ~f[1];
    xr = f[1] & ~f[0];
    xo = f[2];
    // Two-cycle sync delay, then a DB-sample agreement window
    for (int k = 0; k < 3; k++) begin
      sy    = d2[k];
      d2[k] = d1[k];
      d1[k] = pr[k];
      for (int j = DB - 1; j > 0; j--) begin
        w[k][j] = w[k][j-1];
      end
      w[k][0] = sy;
      if (wn[k] < DB) wn[k]++;
      m_s1[k] = m_s[k];
      all = (wn[k] == DB);
      for (int j = 0; j < DB; j++) begin
        all = all && (w[k][j] != m_s[k]);
      end
      if (all) m_s[k] = ~m_s[k];
    end
    // Gravity: tick when L cycles have elapsed
    xt = 1'b0;
    if (!ge) begin
      e = 0;
    end else begin
      e++;
      if (e >= (sd ? FA : GR)) begin
        xt = 1'b1;
        e  = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("left_final",   {31'b0, lf}, {31'b0, xl});
    chk("right_final",  {31'b0, rf}, {31'b0, xr});
    chk("rot_final",    {31'b0, of}, {31'b0, xo});
    chk("tick_gravity", {31'b0, tg}, {31'b0, xt});
    ph++;
    if (lf === 1'b1) begin
      nl++;
      ll = ph;
      if (fl < 0) fl = ph;
    end
    if (rf === 1'b1) nr++;
    if (of === 1'b1) begin
      no++;
      if (fo < 0) fo = ph;
    end
    if (tg === 1'b1) begin
      nt++;
      lt = ph;
      if (ft < 0) ft = ph;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    ph = 0;
    nl = 0;
    nr = 0;
    no = 0;
    nt = 0;
    fl = -1;
    fo = -1;
    ft = -1;
    ll = -1;
    lt = -1;
  endtask

  initial begin
    int base;
    edge_n = 0;
    e      = 0;
    p0[0]  = 0;
    p0[1]  = 0;
    clr();

    // Keys held through reset: outputs 0, then one fresh press
    kl    = 1'b0;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    clr();
    run(7);
    chk("t1_left_latency", 32'(fl), 32'd7);
    run(7);
    chk("t1_left_once", 32'(nl), 32'd1);
    kl = 1'b1;
    run(12);

    // Short glitch ignored, long press gives one pulse
    clr();
    ko = 1'b0;
    run(3);
    ko = 1'b1;
    run(10);
    chk("t2_glitch", 32'(no), 32'd0);
    clr();
    ko = 1'b0;
    run(7);
    chk("t2_rot_latency", 32'(fo), 32'd7);
    run(13);
    chk("t2_rot_once", 32'(no), 32'd1);
    ko = 1'b1;
    run(10);
    chk("t2_rot_release", 32'(no), 32'd1);

    // Left/right conflict
    clr();
    kl = 1'b0;
    kr = 1'b0;
    run(20);
    chk("t3_clash_left",  32'(nl), 32'd0);
    chk("t3_clash_right", 32'(nr), 32'd0);
    kl = 1'b1;
    kr = 1'b1;
    run(10);
    clr();
    kl = 1'b0;
    run(16);
    chk("t3_left_first", 32'(fl), 32'd7);
    chk("t3_left_count", 32'(nl), AR ? 32'd2 : 32'd1);
    kl = 1'b1;
    run(10);

    // Gravity at normal period, disabled before the third tick
    clr();
    ge = 1'b1;
    sd = 1'b0;
    run(25);
    ge = 1'b0;
    run(10);
    chk("t4_first_tick", 32'(ft), 32'd10);
    chk("t4_last_tick",  32'(lt), 32'd20);
    chk("t4_tick_count", 32'(nt), 32'd2);

    // Soft drop switched on above the fast limit
    clr();
    ge = 1'b1;
    run(6);
    chk("t5_quiet", 32'(nt), 32'd0);
    sd = 1'b1;
    run(1);
    chk("t5_switch_tick", {31'b0, tg}, 32'd1);
    run(9);
    chk("t5_fast_count", 32'(nt), 32'd4);
    chk("t5_fast_last",  32'(lt), 32'd16);
    ge = 1'b0;
    sd = 1'b0;
    run(3);

    // Long hold of left (repeats only with the option built in)
    clr();
    kl = 1'b0;
    run(27);
    chk("t6_hold_count", 32'(nl), AR ? 32'd6 : 32'd1);
    chk("t6_hold_last",  32'(ll), AR ? 32'd27 : 32'd7);
    kl = 1'b1;
    run(6);
    base = nl;
    run(15);
    chk("t6_after_release", 32'(nl - base), 32'd0);

    // Random traffic against the model
    clr();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) kl = ~kl;
      if ($urandom_range(0, 7) == 0) kr = ~kr;
      if ($urandom_range(0, 7) == 0) ko = ~ko;
      if ($urandom_range(0, 39) == 0) ge = ~ge;
      if ($urandom_range(0, 9) == 0) sd = ~sd;
      reset = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
